// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  // Width of the branch-penalty down counter.
  localparam int CNT_W = 3;

  // Pipeline register bank indices.
  localparam int IDX_IFID  = 0;
  localparam int IDX_IDEX  = 1;
  localparam int IDX_EXMEM = 2;
  localparam int IDX_MEMWB = 3;

  // Sequencer state. Encoding 2'd3 is unused and recovers to RUN.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_penalty_counter.sv
// Down counter tracking the remaining IF/ID flush cycles after a taken
// branch. Reset is synchronous and active-low. Load has priority over
// decrement.
module penalty_counter
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_is_one
);

  logic [CNT_W-1:0] r_cnt;

  // Count register: clear, load or decrement.
  // NOTE: clocked state is assigned with <= so every flop samples the
  // pre-edge values; a blocking = here would create ordering races.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_is_one = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer. Drives PC and pipeline-bank enables and
// per-bank bubble selects, arbitrating data-memory wait, taken-branch
// flush and load-use hazard by fixed priority. Outputs are Mealy.
// Optional build macro PIPE_CTRL_PERF_EN adds the stall_cycles and
// flush_events performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES     = 4,
  parameter int BR_PENALTY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_use_hazard,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_en,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] bubble,
  output logic              stalled,
  output logic [1:0]        ctrl_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [7:0]        flush_events
`endif
);

  localparam logic [CNT_W-1:0] LP_FLUSH_LOAD = CNT_W'(BR_PENALTY - 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next_state;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_cnt_is_one;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_mem_stall;
  logic              w_pc_en;
  logic [STAGES-1:0] w_stage_en;
  logic [STAGES-1:0] w_bubble;

  assign w_mem_stall = mem_req & ~mem_ack;

  penalty_counter u_penalty_counter (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_load     (w_cnt_load),
    .i_load_val (LP_FLUSH_LOAD),
    .i_dec      (w_cnt_dec),
    .o_cnt      (w_cnt),
    .o_is_one   (w_cnt_is_one)
  );

  // State register; reset abandons any flush or wait in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, counter control and Mealy outputs.
  // NOTE: every signal gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_pc_en      = 1'b1;
    w_stage_en   = '1;
    w_bubble     = '0;

    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_pc_en      = 1'b0;
          w_stage_en   = '0;
          w_next_state = MEM_WAIT;
        end else if (branch_taken) begin
          w_bubble[IDX_IFID] = 1'b1;
          w_bubble[IDX_IDEX] = 1'b1;
          if (BR_PENALTY > 1) begin
            w_cnt_load   = 1'b1;
            w_next_state = FLUSH;
          end
        end else if (load_use_hazard) begin
          w_pc_en              = 1'b0;
          w_stage_en[IDX_IFID] = 1'b0;
          w_bubble[IDX_IDEX]   = 1'b1;
        end
      end

      FLUSH: begin
        if (w_mem_stall) begin
          // Counter holds so the flush resumes after the wait.
          w_pc_en      = 1'b0;
          w_stage_en   = '0;
          w_next_state = MEM_WAIT;
        end else begin
          w_bubble[IDX_IFID] = 1'b1;
          w_cnt_dec          = 1'b1;
          if (w_cnt_is_one) begin
            w_next_state = RUN;
          end
        end
      end

      MEM_WAIT: begin
        if (!mem_ack) begin
          w_pc_en    = 1'b0;
          w_stage_en = '0;
        end else begin
          if (w_cnt != '0) begin
            w_bubble[IDX_IFID] = 1'b1;
            w_cnt_dec          = 1'b1;
          end
          // More than one flush cycle left after this decrement.
          w_next_state = (w_cnt > CNT_W'(2)) ? FLUSH : RUN;
        end
      end

      default: begin
        w_next_state = RUN;
      end
    endcase

    if (!reset) begin
      w_pc_en    = 1'b0;
      w_stage_en = '0;
      w_bubble   = '1;
    end
  end

  assign pc_en      = w_pc_en;
  assign stage_en   = w_stage_en;
  assign bubble     = w_bubble;
  assign stalled    = ~w_pc_en;
  assign ctrl_state = r_state;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] r_stall_cycles;
  logic [7:0]  r_flush_events;
  logic        w_br_accept;

  assign w_br_accept = (r_state == RUN) & ~w_mem_stall & branch_taken;

  // Saturating stall counter and wrapping accepted-branch counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (!w_pc_en && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (w_br_accept) begin
        r_flush_events <= r_flush_events + 8'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl. Two instances (BR_PENALTY = 2 and 4)
// share the same stimulus. A behavioural model predicts each cycle's
// outputs; the stimulus side pushes predictions, a monitor pops and
// compares on the falling edge.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic [1:0]  st;
    logic        pc;
    logic [3:0]  se;
    logic [3:0]  bub;
    logic        stl;
    logic [15:0] sc;
    logic [7:0]  fe;
  } exp_t;

  typedef struct packed {
    exp_t d1;
    exp_t d0;
  } pair_t;

  logic clk = 1'b0;
  logic reset, luh, br, req, ack;

  logic        a_pc  [2];
  logic        a_stl [2];
  logic [3:0]  a_se  [2];
  logic [3:0]  a_bub [2];
  logic [1:0]  a_st  [2];
  logic [15:0] a_sc  [2];
  logic [7:0]  a_fe  [2];

  pair_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Model state: mode 0 = run, 1 = flushing, 2 = waiting on memory.
  int mode [2];
  int cnt  [2];
  int sc   [2];
  int fe   [2];

  always #5 clk = ~clk;

  pipeline_ctrl #(.STAGES(4), .BR_PENALTY(2)) u_dut_p2 (
    .clk             (clk),
    .reset           (reset),
    .load_use_hazard (luh),
    .branch_taken    (br),
    .mem_req         (req),
    .mem_ack         (ack),
    .pc_en           (a_pc[0]),
    .stage_en        (a_se[0]),
    .bubble          (a_bub[0]),
    .stalled         (a_stl[0]),
    .ctrl_state      (a_st[0])
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles    (a_sc[0]),
    .flush_events    (a_fe[0])
`endif
  );

  pipeline_ctrl #(.STAGES(4), .BR_PENALTY(4)) u_dut_p4 (
    .clk             (clk),
    .reset           (reset),
    .load_use_hazard (luh),
    .branch_taken    (br),
    .mem_req         (req),
    .mem_ack         (ack),
    .pc_en           (a_pc[1]),
    .stage_en        (a_se[1]),
    .bubble          (a_bub[1]),
    .stalled         (a_stl[1]),
    .ctrl_state      (a_st[1])
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles    (a_sc[1]),
    .flush_events    (a_fe[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Predict this cycle's outputs for instance k and advance its model.
  task automatic model_step(input int k, output exp_t e);
    int  p;
    bit  mstall;
    p      = (k == 0) ? 2 : 4;
    mstall = req && !ack;
    e.st   = 2'(mode[k]);
    e.sc   = 16'(sc[k]);
    e.fe   = 8'(fe[k]);
    e.se   = 4'hF;
    e.pc   = 1'b1;
    e.bub  = 4'h0;
    if (!reset) begin
      e.se = 4'h0; e.pc = 1'b0; e.bub = 4'hF;
      mode[k] = 0; cnt[k] = 0; sc[k] = 0; fe[k] = 0;
    end else begin
      if (mode[k] == 0) begin
        if (mstall) begin
          e.se = 4'h0; e.pc = 1'b0; mode[k] = 2;
        end else if (br) begin
          e.bub = 4'b0011;
          fe[k] = (fe[k] + 1) % 256;
          if (p > 1) begin cnt[k] = p - 1; mode[k] = 1; end
        end else if (luh) begin
          e.se = 4'b1110; e.pc = 1'b0; e.bub = 4'b0010;
        end
      end else if (mode[k] == 1) begin
        if (mstall) begin
          e.se = 4'h0; e.pc = 1'b0; mode[k] = 2;
        end else begin
          e.bub = 4'b0001;
          if (cnt[k] == 1) mode[k] = 0;
          cnt[k] = (cnt[k] + 7) % 8;
        end
      end else begin
        if (!ack) begin
          e.se = 4'h0; e.pc = 1'b0;
        end else begin
          if (cnt[k] != 0) begin e.bub = 4'b0001; cnt[k] = cnt[k] - 1; end
          mode[k] = (cnt[k] > 1) ? 1 : 0;
        end
      end
      if (!e.pc && sc[k] < 65535) sc[k] = sc[k] + 1;
    end
    e.stl = !e.pc;
  endtask

  task automatic cycle(input logic r, input logic l, input logic b, input logic m, input logic a);
    pair_t p;
    @(posedge clk);
    #1;
    reset = r; luh = l; br = b; req = m; ack = a;
    model_step(0, p.d0);
    model_step(1, p.d1);
    sb.push_back(p);
  endtask

  task automatic compare(input int k, input exp_t e);
    string t;
    t = (k == 0) ? "p2" : "p4";
    check({t, ".ctrl_state"}, 32'(a_st[k]),  32'(e.st));
    check({t, ".pc_en"},      32'(a_pc[k]),  32'(e.pc));
    check({t, ".stage_en"},   32'(a_se[k]),  32'(e.se));
    check({t, ".bubble"},     32'(a_bub[k]), 32'(e.bub));
    check({t, ".stalled"},    32'(a_stl[k]), 32'(e.stl));
`ifdef PIPE_CTRL_PERF_EN
    check({t, ".stall_cycles"}, 32'(a_sc[k]), 32'(e.sc));
    check({t, ".flush_events"}, 32'(a_fe[k]), 32'(e.fe));
`endif
  endtask

  // Monitor: one prediction per cycle, compared mid-cycle.
  initial begin
    pair_t p;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        p = sb.pop_front();
        compare(0, p.d0);
        compare(1, p.d1);
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; cnt[k] = 0; sc[k] = 0; fe[k] = 0;
    end
    reset = 1'b0; luh = 1'b1; br = 1'b1; req = 1'b1; ack = 1'b1;

    // Reset held with all inputs high, then released.
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Single load-use pulse.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Taken branch and its flush.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Five-cycle memory wait then ack.
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // All stall sources at once; branch still high after the ack.
    repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Reset during a flush.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Flush interrupted by a memory wait.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(99) >= 2),
            ($urandom_range(99) < 25),
            ($urandom_range(99) < 15),
            ($urandom_range(99) < 30),
            ($urandom_range(99) < 50));
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the pipelined datapath.
- Drives the enable input of every pipeline register bank (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register, all of which are built from enable-gated flip-flops.
- Drives per-bank bubble (NOP-insert) selects.
- Arbitrates three stall sources by fixed priority: data-memory wait, taken-branch flush, load-use hazard.

Parameters:
- STAGES, 4, number of pipeline register banks; index 0 = IF/ID through 3 = MEM/WB.
- BR_PENALTY, 2, cycles IF/ID is flushed after a taken branch; legal range 1..7.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-low; 0 on a rising edge resets the block.
- load_use_hazard, input, 1, instruction in ID consumes the result of a load currently in EX.
- branch_taken, input, 1, EX resolved a taken branch this cycle.
- mem_req, input, 1, MEM stage is accessing data memory.
- mem_ack, input, 1, data memory completes the access this cycle.
- pc_en, output, 1, PC register write enable.
- stage_en, output, STAGES, write enable per pipeline register bank.
- bubble, output, STAGES, 1 = bank loads NOP/zero control instead of its input (meaningful only when that bank's stage_en = 1).
- stalled, output, 1, 1 whenever pc_en = 0.
- ctrl_state, output, 2, current FSM state (debug).

Behaviour:
- Outputs are combinational from registered state plus current inputs (Mealy). state and flush counter are registered.
- FSM states: RUN = 0, FLUSH = 1, MEM_WAIT = 2; encoding 3 is unused and recovers to RUN.
- Reset (reset = 0 at an edge) sets state = RUN and cnt = 0.
- While reset is low, outputs are: stage_en = 0, pc_en = 0, bubble = all 1s, stalled = 1.
- Reset asserted mid-operation abandons any flush or wait. Normal RUN behaviour starts in the first cycle after reset is released.
- RUN, priority 1, memory stall (mem_req = 1 and mem_ack = 0):
  - stage_en = 0, pc_en = 0, bubble = 0.
  - next state = MEM_WAIT.
- RUN, priority 1, memory same-cycle ack (mem_req = 1 and mem_ack = 1): no stall; fall through to the next priority check.
- RUN, priority 2, taken branch (branch_taken = 1):
  - stage_en = all 1s, pc_en = 1 (PC loads the target), bubble[0] = 1, bubble[1] = 1.
  - If BR_PENALTY > 1: cnt <= BR_PENALTY-1, next state = FLUSH. Otherwise remain in RUN.
  - load_use_hazard is ignored in this cycle.
- RUN, priority 3, load-use hazard (load_use_hazard = 1):
  - pc_en = 0, stage_en[0] = 0 (hold IF/ID), stage_en[STAGES-1:1] = all 1s, bubble[1] = 1.
  - Stays in RUN. Each hazard cycle costs exactly one cycle.
- RUN, none of the above: stage_en = all 1s, pc_en = 1, bubble = 0.
- FLUSH:
  - Outputs: stage_en = all 1s, pc_en = 1, bubble[0] = 1, other bubbles 0.
  - cnt decrements each cycle; when cnt = 1, next state = RUN.
  - load_use_hazard and branch_taken are ignored (ID/EX hold bubbles).
  - mem_req = 1 with mem_ack = 0 takes priority: outputs as for the RUN memory stall, cnt frozen, next state = MEM_WAIT, and FLUSH resumes afterwards (see MEM_WAIT).
- MEM_WAIT:
  - While mem_ack = 0: stage_en = 0, pc_en = 0, bubble = 0.
  - The cycle mem_ack = 1: outputs equal the RUN no-hazard outputs; if cnt != 0, bubble[0] = 1 and cnt decrements.
  - After ack, next state = FLUSH if cnt > 1 after decrement, else RUN. cnt reaching 0 or 1 returns to RUN.
  - branch_taken and load_use_hazard are ignored during MEM_WAIT. They are re-evaluated after the wait because the EX/ID contents were held.
- Waits are unbounded; there is no timeout.
- stalled = ~pc_en at all times.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined:
  - Adds output stall_cycles, 16-bit.
  - Increments on every cycle with reset = 1 and pc_en = 0; saturates at 16'hFFFF.
  - Cleared by reset.
  - Adds output flush_events, 8-bit, wrapping; increments on each accepted branch_taken.
- When undefined: neither port exists and no counter logic is generated.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum type ctrl_state_t: RUN, FLUSH, MEM_WAIT.
  - Bank index constants IDX_IFID = 0, IDX_IDEX = 1, IDX_EXMEM = 2, IDX_MEMWB = 3.
  - CNT_W = 3.
- One sub-module, penalty_counter: 3-bit down counter with synchronous active-low reset, load, load value, decrement enable, and an is_one flag.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with all inputs 1 -> stage_en = 4'b0000, pc_en = 0, bubble = 4'b1111. Release -> RUN, ctrl_state = 0, stage_en = 4'b1111.
- Load-use: pulse load_use_hazard for 1 cycle in RUN -> that cycle pc_en = 0, stage_en = 4'b1110, bubble = 4'b0010. Next cycle all enables 1 and bubble = 0.
- Branch with BR_PENALTY = 2: branch_taken for 1 cycle -> cycle 0 bubble = 4'b0011, pc_en = 1. Cycle 1 in FLUSH with bubble = 4'b0001. Cycle 2 in RUN with bubble = 0.
- Memory wait: mem_req = 1, mem_ack = 0 for 5 cycles, then mem_ack = 1 -> stage_en = 0 for 5 cycles. Ack cycle stage_en = 4'b1111 and state returns to RUN. With PIPE_CTRL_PERF_EN, stall_cycles = 5.
- Priority: mem stall, branch and load-use all asserted in RUN -> MEM_WAIT entered. After ack with branch_taken still 1 -> branch flush sequence runs. Load-use is never honoured during a flush.
- Reset mid-FLUSH: BR_PENALTY = 4, assert reset = 0 after the first flush cycle -> after release state = RUN, bubble = 0, no residual flush cycles.
